reg_dump_scanner: RTL and testbench

Debug read-out engine that drives the processor's register-select port (`reg_sel`) and consumes the returned register value (`reg_data`). On a start pulse it walks a configurable range of the 32 general registers, snapshots each value and streams it out as bytes over a valid/ready interface, for a UART transmitter or display driver. It sits between `sccomp` and the board I/O, replacing bench-side `reg_sel` poking in hardware builds.

---
 rtl/reg_dump_scanner.sv | 138 +++++++++++++
 tb/tb_reg_dump_scanner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_scanner.sv
// Walks registers FIRST_REG..LAST_REG through reg_sel and streams each snapshot out as bytes.
// Optional REGDUMP_TAG_EN prefixes every register with a {3'b101, reg_sel} tag byte.
module reg_dump_scanner #(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

`ifdef REGDUMP_TAG_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
    localparam logic [4:0] FIRST_SEL = 5'(FIRST_REG);
    localparam logic [4:0] LAST_SEL  = 5'(LAST_REG);

    if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_bad_range
        $error("reg_dump_scanner: register range %0d..%0d is invalid", FIRST_REG, LAST_REG);
    end

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_CAPT, S_SEND, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_sel;
    logic [31:0] r_snap;
    logic [2:0]  r_cnt;
    logic        w_hs;
    logic        w_last_byte;
    logic [1:0]  w_idx;
    logic [1:0]  w_lane;
    logic [7:0]  w_byte;

    assign w_hs        = (r_state == S_SEND) && out_ready;
    assign w_last_byte = (r_cnt == LAST_BYTE);
    assign reg_sel     = r_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SEL;
            S_SEL:   w_next = S_CAPT;
            S_CAPT:  w_next = S_SEND;
            S_SEND: begin
                if (w_hs && w_last_byte) begin
                    w_next = (r_sel == LAST_SEL) ? S_DONE : S_SEL;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Register index, snapshot and byte counter; reg_sel never steps past LAST_SEL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sel  <= 5'd0;
            r_snap <= 32'd0;
            r_cnt  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_sel <= FIRST_SEL;
                end
                S_CAPT: begin
                    r_snap <= reg_data;
                    r_cnt  <= 3'd0;
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (!w_last_byte) begin
                            r_cnt <= r_cnt + 3'd1;
                        end else if (r_sel != LAST_SEL) begin
                            r_sel <= r_sel + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
`ifdef REGDUMP_TAG_EN
        w_idx = r_cnt[1:0] - 2'd1;
`else
        w_idx = r_cnt[1:0];
`endif
        w_lane = BIG_ENDIAN ? (2'd3 - w_idx) : w_idx;
        case (w_lane)
            2'd0:    w_byte = r_snap[7:0];
            2'd1:    w_byte = r_snap[15:8];
            2'd2:    w_byte = r_snap[23:16];
            default: w_byte = r_snap[31:24];
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_SEL, S_CAPT: busy = 1'b1;
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
`ifdef REGDUMP_TAG_EN
                out_data  = (r_cnt == 3'd0) ? {3'b101, r_sel} : w_byte;
`else
                out_data  = w_byte;
`endif
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed scenarios with randomized register contents and out_ready stalls, checked against a byte-list model.
module tb_reg_dump_scanner;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] regs [32];
    logic        st   [3];
    logic        rdy  [3];
    logic [4:0]  sel  [3];
    logic [31:0] rd   [3];
    logic [7:0]  od   [3];
    logic        ov   [3];
    logic        bz   [3];
    logic        dn   [3];

    int fr  [3];
    int lr  [3];
    bit ber [3];

    int total = 0;
    int bad   = 0;
    int done_e;
    int first_v;
    int sl = 0;
    int bpr;
    int toff;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] full_q [$];

    always #5 clk = ~clk;

    assign rd[0] = regs[sel[0]];
    assign rd[1] = regs[sel[1]];
    assign rd[2] = regs[sel[2]];

    reg_dump_scanner u_full (
        .clk(clk), .rstn(rstn), .start(st[0]), .reg_sel(sel[0]), .reg_data(rd[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .busy(bz[0]), .done(dn[0])
    );

    reg_dump_scanner #(.FIRST_REG(7), .LAST_REG(7), .BIG_ENDIAN(1'b0)) u_one (
        .clk(clk), .rstn(rstn), .start(st[1]), .reg_sel(sel[1]), .reg_data(rd[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .busy(bz[1]), .done(dn[1])
    );

    reg_dump_scanner #(.FIRST_REG(3), .LAST_REG(4), .BIG_ENDIAN(1'b1)) u_pair (
        .clk(clk), .rstn(rstn), .start(st[2]), .reg_sel(sel[2]), .reg_data(rd[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .busy(bz[2]), .done(dn[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected byte list straight from the register values and the dump rules.
    task automatic build_exp(input int k);
        int sh;
        exp_q.delete();
        for (int r = fr[k]; r <= lr[k]; r++) begin
            if (toff == 1) exp_q.push_back(8'hA0 + 8'(r));
            for (int i = 0; i < 4; i++) begin
                sh = ber[k] ? (24 - 8 * i) : (8 * i);
                exp_q.push_back(8'(regs[r] >> sh));
            end
        end
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    // Start a dump on instance k and collect accepted bytes until done (or abort after abort_n bytes).
    task automatic run(input int k, input bit stall, input bit chg7, input int abort_n);
        logic [7:0] pod;
        logic [4:0] psel;
        bit prev_stall;
        bit aborted;
        int e;
        got_q.delete();
        done_e = -1;
        first_v = -1;
        prev_stall = 1'b0;
        aborted = 1'b0;
        pod = 8'd0;
        psel = 5'd0;
        @(negedge clk);
        st[k] = 1'b1;
        @(posedge clk);
        #1 st[k] = 1'b0;
        e = 0;
        while (e < 5000) begin
            @(negedge clk);
            if (e == 0) begin
                check("busy_after_start", 64'(bz[k]), 64'd1);
                check("sel_after_start", 64'(sel[k]), 64'(fr[k]));
            end
            if (prev_stall) begin
                check("stall_data_stable", 64'(od[k]), 64'(pod));
                check("stall_sel_stable", 64'(sel[k]), 64'(psel));
            end
            if (dn[k]) begin
                done_e = e;
                break;
            end
            if (abort_n >= 0 && ov[k] && got_q.size() == abort_n) begin
                rstn = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (ov[k] && first_v < 0) first_v = e;
            if (stall) begin
                if (sl > 0) begin
                    rdy[k] = 1'b0;
                    sl--;
                end else begin
                    rdy[k] = 1'b1;
                    if ($urandom_range(0, 2) == 0) sl = $urandom_range(1, 10);
                end
            end else begin
                rdy[k] = 1'b1;
            end
            if (chg7 && ov[k] && sel[k] == 5'd7) regs[7] = 32'h0;
            if (ov[k] && rdy[k]) got_q.push_back(od[k]);
            prev_stall = ov[k] && !rdy[k];
            pod = od[k];
            psel = sel[k];
            @(posedge clk);
            e++;
        end
        rdy[k] = 1'b1;
        if (!aborted) check("done_within_budget", 64'(done_e >= 0), 64'd1);
    endtask

    initial begin
`ifdef REGDUMP_TAG_EN
        bpr = 5;
        toff = 1;
`else
        bpr = 4;
        toff = 0;
`endif
        fr[0] = 0;  lr[0] = 31; ber[0] = 1'b1;
        fr[1] = 7;  lr[1] = 7;  ber[1] = 1'b0;
        fr[2] = 3;  lr[2] = 4;  ber[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            rdy[i] = 1'b1;
        end
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0;
        regs[7] = 32'h12345678;
        regs[31] = 32'hDEADBEEF;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_reg_sel", 64'(sel[0]), 64'd0);
        check("rst_out_data", 64'(od[0]), 64'd0);
        check("rst_out_valid", 64'(ov[0]), 64'd0);
        check("rst_busy", 64'(bz[0]), 64'd0);
        check("rst_done", 64'(dn[0]), 64'd0);
        rstn = 1'b1;

        // Full default dump, sink always ready.
        build_exp(0);
        run(0, 1'b0, 1'b0, -1);
        cmp_stream("full_stream");
        check("full_done_cycle", 64'(done_e), 64'(32 * (2 + bpr)));
        check("full_first_valid", 64'(first_v), 64'd2);
        check("r7_byte0", 64'(got_q[7 * bpr + toff + 0]), 64'h12);
        check("r7_byte1", 64'(got_q[7 * bpr + toff + 1]), 64'h34);
        check("r7_byte2", 64'(got_q[7 * bpr + toff + 2]), 64'h56);
        check("r7_byte3", 64'(got_q[7 * bpr + toff + 3]), 64'h78);
        full_q = got_q;
        @(negedge clk);
        check("full_done_single", 64'(dn[0]), 64'd0);
        check("full_busy_after", 64'(bz[0]), 64'd0);
        check("full_sel_holds", 64'(sel[0]), 64'd31);

        // Single little-endian register, plus start coinciding with done.
        build_exp(1);
        run(1, 1'b0, 1'b0, -1);
        cmp_stream("one_stream");
        check("one_first_data", 64'(got_q[toff]), 64'h78);
        check("one_done_cycle", 64'(done_e), 64'(2 + bpr));
        st[1] = 1'b1;
        @(posedge clk);
        #1 st[1] = 1'b0;
        @(negedge clk);
        check("start_at_done_ignored", 64'(bz[1]), 64'd0);
        check("one_done_single", 64'(dn[1]), 64'd0);
        check("one_sel_holds", 64'(sel[1]), 64'd7);

        // Random back-pressure must not change the byte sequence.
        exp_q = full_q;
        run(0, 1'b1, 1'b0, -1);
        cmp_stream("stall_stream");

        // Register changes after capture must not leak into the stream.
        exp_q = full_q;
        run(0, 1'b0, 1'b1, -1);
        cmp_stream("snapshot_stream");
        check("r7_was_changed", 64'(regs[7]), 64'h0);
        regs[7] = 32'h12345678;

        // Asynchronous reset in the middle of r5, then a fresh dump from r0.
        run(0, 1'b0, 1'b0, 5 * bpr + toff + 2);
        #1;
        check("abort_reg_sel", 64'(sel[0]), 64'd0);
        check("abort_out_data", 64'(od[0]), 64'd0);
        check("abort_out_valid", 64'(ov[0]), 64'd0);
        check("abort_busy", 64'(bz[0]), 64'd0);
        check("abort_done", 64'(dn[0]), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_q = full_q;
        run(0, 1'b0, 1'b0, -1);
        cmp_stream("restart_stream");

        // Two-register window, with tag bytes when the tag build is selected.
        build_exp(2);
        run(2, 1'b0, 1'b0, -1);
        cmp_stream("pair_stream");
        check("pair_len", 64'(got_q.size()), 64'(2 * bpr));
        check("pair_first", 64'(got_q[0]), (toff == 1) ? 64'hA3 : 64'(regs[3][31:24]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
